// File: rtl/audio_playback_controller_if.sv
// Sample-memory read port and serializer load/shift port of the playback controller.
interface audio_playback_controller_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [15:0]           mem_data;
  logic [15:0]           ser_data;
  logic                  ser_load;
  logic                  bit_tick;

  // Controller side: drives memory address/strobe and the serializer.
  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_data,
    output ser_data,
    output ser_load,
    output bit_tick
  );

  // Memory/serializer side.
  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_data,
    input  ser_data,
    input  ser_load,
    input  bit_tick
  );
endinterface

// File: rtl/audio_playback_controller.sv
// Audio playback sequencer: walks a sample-memory address range, double-buffers
// the next word and feeds a 16-bit serializer with load strobes and bit ticks.
module audio_playback_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 33
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [ADDR_WIDTH-1:0]     start_addr,
  input  logic [ADDR_WIDTH-1:0]     end_addr,
  audio_playback_controller_if.master bus,
  output logic                      audio_enable,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(14);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    FINISH
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q;
  logic                  fetch_d;
  logic [15:0]           ser_data_q;
  logic                  ser_load_q;
  logic                  bit_tick_q;
  logic [15:0]           next_buf;
  logic                  next_valid;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div;

  logic                  next_ok_c;
  logic [ADDR_WIDTH-1:0] next_addr_c;

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_load  = ser_load_q;
  assign bus.bit_tick  = bit_tick_q;

  // Address of the word following ptr; none after end_addr unless looping.
  always_comb begin
    next_ok_c   = 1'b1;
    next_addr_c = ptr + ADDR_WIDTH'(1);
    if (ptr == last_addr) begin
      next_addr_c = first_addr;
      next_ok_c   = loop_en;
    end
  end

  // Playback state machine with registered outputs; stop beats every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      first_addr   <= '0;
      last_addr    <= '0;
      ptr          <= '0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      fetch_d      <= 1'b0;
      ser_data_q   <= '0;
      ser_load_q   <= 1'b0;
      bit_tick_q   <= 1'b0;
      next_buf     <= '0;
      next_valid   <= 1'b0;
      bit_cnt      <= '0;
      div          <= '0;
      audio_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      ser_load_q  <= 1'b0;
      bit_tick_q  <= 1'b0;
      done        <= 1'b0;
      fetch_d     <= mem_rd_en_q;
      if (state != IDLE && stop) begin
        state        <= IDLE;
        mem_addr_q   <= '0;
        ser_data_q   <= '0;
        fetch_d      <= 1'b0;
        next_valid   <= 1'b0;
        bit_cnt      <= '0;
        div          <= '0;
        audio_enable <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop && (start_addr <= end_addr)) begin
              state        <= FETCH;
              first_addr   <= start_addr;
              last_addr    <= end_addr;
              ptr          <= start_addr;
              mem_addr_q   <= start_addr;
              mem_rd_en_q  <= 1'b1;
              audio_enable <= 1'b1;
              busy         <= 1'b1;
            end
          end
          FETCH: state <= WAIT;
          WAIT: begin
            state      <= PLAY;
            ser_data_q <= bus.mem_data;
            ser_load_q <= 1'b1;
            bit_tick_q <= 1'b1;
            bit_cnt    <= '0;
            div        <= '0;
            next_valid <= 1'b0;
            if (next_ok_c) begin
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= next_addr_c;
              ptr         <= next_addr_c;
            end
          end
          PLAY: begin
            if (fetch_d) begin
              next_buf   <= bus.mem_data;
              next_valid <= 1'b1;
            end
            if (div == DIV_LAST) begin
              div <= '0;
              if (bit_cnt == BIT_LAST) begin
                if (next_valid) begin
                  ser_data_q <= next_buf;
                  ser_load_q <= 1'b1;
                  bit_tick_q <= 1'b1;
                  bit_cnt    <= '0;
                  next_valid <= 1'b0;
                  if (next_ok_c) begin
                    mem_rd_en_q <= 1'b1;
                    mem_addr_q  <= next_addr_c;
                    ptr         <= next_addr_c;
                  end
                end else begin
                  state        <= IDLE;
                  mem_addr_q   <= '0;
                  bit_cnt      <= '0;
                  audio_enable <= 1'b0;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                end
              end else begin
                bit_tick_q <= 1'b1;
                bit_cnt    <= bit_cnt + CNT_W'(1);
                // Last bit of the final word: run out its bit period in FINISH.
                if (bit_cnt == BIT_PENULT && !next_valid && !fetch_d) begin
                  state <= FINISH;
                end
              end
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          FINISH: begin
            if (div == DIV_LAST) begin
              state        <= IDLE;
              div          <= '0;
              bit_cnt      <= '0;
              mem_addr_q   <= '0;
              audio_enable <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              div <= div + DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/audio_playback_controller.md
Name: audio_playback_controller

Overview:
- Sequences audio playback from a synchronous sample memory into the 16-bit audio serializer.
- Walks an address range, fetches 16-bit words, and double-buffers the next word.
- Issues a word-load strobe and a divided bit-rate tick to the serializer, drives the board audio enable, and supports one-shot, looping and abort.
- Sits between the sample memory/address logic and the serializer in the audio output path.

Parameters:
- ADDR_WIDTH, 16, width of memory word address.
- CLK_DIV, 33, clock cycles per serial bit (bit_tick period); legal range 4..65535.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begin playback at start_addr (ignored unless IDLE)
- stop  input  1  pulse; abort playback immediately
- loop_en  input  1  1 = wrap end_addr→start_addr; sampled live at each wrap decision
- start_addr  input  ADDR_WIDTH  first word address; sampled on accepted start
- end_addr  input  ADDR_WIDTH  last word address, inclusive; sampled on accepted start
- mem_addr  output  ADDR_WIDTH  sample memory read address
- mem_rd_en  output  1  read strobe; mem_data is valid exactly 1 cycle later
- mem_data  input  16  sample word from memory
- ser_data  output  16  word for serializer; held stable between loads
- ser_load  output  1  1-cycle pulse: serializer loads ser_data, MSB shifted first
- bit_tick  output  1  1-cycle serializer shift enable, once per CLK_DIV cycles while playing
- audio_enable  output  1  audio amplifier enable; high from accepted start until playback end
- busy  output  1  high in any non-IDLE state
- done  output  1  1-cycle pulse on natural completion only

Behaviour:
- Reset: state IDLE; all outputs 0; internal pointer, bit counter, divider and next-word buffer cleared. Reset overrides every input.
- States: IDLE, FETCH, WAIT, PLAY, FINISH.
- Cycle numbering: start is sampled high in cycle 0.
- IDLE:
  - start=1, stop=0 and start_addr<=end_addr → FETCH. Latch start_addr and end_addr; ptr=start_addr.
  - start_addr>end_addr → start ignored, stay IDLE.
- FETCH (cycle 1): mem_rd_en=1, mem_addr=ptr, audio_enable=1 → WAIT.
- WAIT (cycle 2): capture mem_data as the current word → PLAY.
- PLAY entry (cycle 3): ser_load=1 and bit_tick=1 with ser_data=word; bit_cnt=0; divider restarts.
- PLAY, bit timing: bit_tick asserts every CLK_DIV cycles; bit_cnt increments on each tick and wraps 15→0.
- PLAY, prefetch: in any cycle where ser_load=1 and a next word exists, assert mem_rd_en with mem_addr = next address. Capture mem_data the following cycle into next_buf and set next_valid=1.
- Next address:
  - ptr<end_addr → ptr+1.
  - ptr==end_addr and loop_en=1 → start_addr.
  - ptr==end_addr and loop_en=0 → none (last word).
  - loop_en is evaluated in the ser_load cycle of the word at end_addr.
- Word boundary: the tick that would begin bit 16 (bit_cnt==15 then tick):
  - next_valid=1 → this tick carries ser_load=1, ser_data=next_buf, next_valid=0, bit_cnt=0, and the prefetch rule applies.
  - No next word → no ser_load, no bit_tick; go to FINISH.
- Underrun cannot occur: a fetch completes in 2 cycles, far less than a word time of 16·CLK_DIV cycles.
- FINISH: one full bit period after the last bit_tick of the final word, go to IDLE.
  - In that first IDLE cycle: done=1, audio_enable=0, busy=0.
  - ser_data holds its last value; all other outputs are 0.
- stop:
  - Any non-IDLE state: stop=1 forces IDLE next cycle; all outputs 0; next_valid cleared; no done.
  - stop has priority over a simultaneous start, a word boundary or the FINISH exit.
  - stop in IDLE: no effect.
- start while busy: ignored (no restart).
- Address arithmetic wraps modulo 2^ADDR_WIDTH; because start_addr<=end_addr is required, ptr never passes end_addr.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with start=1 held → all outputs 0 while reset high. After release, start accepted normally.
- CLK_DIV=4, start=end=0x10, mem[0x10]=0xA5F0 →
  - mem_rd_en with addr 0x10 at cycle 1.
  - ser_load + bit_tick with ser_data=0xA5F0 at cycle 3.
  - bit_tick at cycles 3,7,…,63 (16 ticks).
  - done=1 and audio_enable=0 at cycle 67; busy high from cycle 1 to 66.
- CLK_DIV=4, range 0x20–0x22, loop_en=0, words 0x1111/0x2222/0x3333 →
  - ser_load at cycles 3/67/131 with those words.
  - Prefetch reads: 0x21 at cycle 3, 0x22 at cycle 67; no read at cycle 131.
  - done at cycle 195.
- CLK_DIV=4, range 0x20–0x21, loop_en=1 → load sequence 0x20,0x21,0x20,0x21,…. Drop loop_en before a 0x21 ser_load → playback ends after that 0x21 word; done pulses once.
- Mid-word at cycle 40: stop=1 with start=1 → cycle 41: IDLE, all outputs 0, no done, no further mem_rd_en or ticks.
- start with start_addr=0x30, end_addr=0x2F → stays IDLE, busy=0. start pulse during PLAY → no restart, sequence unchanged.
